// File: rtl/semaforo_monitor.sv
// semaforo_monitor: receive-side checker for the two-head lamp bus and the modo line.
// Latency: one register stage; every output reflects the sample taken at the latest edge.
// Backpressure: none; the block samples every cycle and never stalls the controller.
module semaforo_monitor #(
  parameter int T_GR = 4,
  parameter int T_YR = 1,
  parameter int T_RG = 3,
  parameter int T_RY = 1,
  parameter int T_FL = 1,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          A_green,
  input  logic          A_yellow,
  input  logic          A_red,
  input  logic          B_green,
  input  logic          B_yellow,
  input  logic          B_red,
  input  logic          modo,
  input  logic          fault_clr,
  output logic [2:0]    phase,
  output logic          phase_valid,
  output logic [DW-1:0] dwell,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [15:0]   cycles
);

  localparam logic [2:0] PH_GR  = 3'd0;
  localparam logic [2:0] PH_YR  = 3'd1;
  localparam logic [2:0] PH_RG  = 3'd2;
  localparam logic [2:0] PH_RY  = 3'd3;
  localparam logic [2:0] PH_YY  = 3'd4;
  localparam logic [2:0] PH_BB  = 3'd5;
  localparam logic [2:0] PH_ILL = 3'd7;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_ILL  = 2'd1;
  localparam logic [1:0] FC_SEQ  = 2'd2;
  localparam logic [1:0] FC_TIM  = 2'd3;

  // Dwell limits carried one bit wider so dwell+1 never overflows in comparisons.
  localparam logic [DW:0] TW_GR = (DW+1)'(T_GR);
  localparam logic [DW:0] TW_YR = (DW+1)'(T_YR);
  localparam logic [DW:0] TW_RG = (DW+1)'(T_RG);
  localparam logic [DW:0] TW_RY = (DW+1)'(T_RY);
  localparam logic [DW:0] TW_FL = (DW+1)'(T_FL);

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic          phase_valid_q, phase_valid_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [15:0]   cycles_q, cycles_d;
  logic          modo_q, modo_d;
  // Set while the current phase began at a SYNC sample, so its true start is unknown.
  logic          partial_q, partial_d;

  logic [2:0]    samp_ph;
  logic          phase_chg;
  logic [1:0]    viol;
  logic [DW:0]   dwell_inc;
  logic [DW:0]   t_cur;
  logic [2:0]    succ_ph;

  // Decode the six lamps into a phase; anything but the six exact patterns is illegal.
  always_comb begin
    samp_ph = PH_ILL;
    case ({A_green, A_yellow, A_red, B_green, B_yellow, B_red})
      6'b100001: samp_ph = PH_GR;
      6'b010001: samp_ph = PH_YR;
      6'b001100: samp_ph = PH_RG;
      6'b001010: samp_ph = PH_RY;
      6'b010010: samp_ph = PH_YY;
      6'b000000: samp_ph = PH_BB;
      default:   samp_ph = PH_ILL;
    endcase
  end

  // Required dwell and normal successor of the previous phase.
  always_comb begin
    t_cur   = TW_GR;
    succ_ph = PH_YR;
    case (phase_q)
      PH_GR:   begin t_cur = TW_GR; succ_ph = PH_YR; end
      PH_YR:   begin t_cur = TW_YR; succ_ph = PH_RG; end
      PH_RG:   begin t_cur = TW_RG; succ_ph = PH_RY; end
      PH_RY:   begin t_cur = TW_RY; succ_ph = PH_GR; end
      default: begin t_cur = TW_FL; succ_ph = PH_GR; end
    endcase
  end

  // Classify the new sample against the previous phase; only meaningful in TRACK.
  always_comb begin
    viol      = FC_NONE;
    dwell_inc = {1'b0, dwell_q} + 1'b1;
    if (samp_ph == PH_ILL) begin
      viol = FC_ILL;
    end else if (phase_q <= PH_RY) begin
      if (!modo_q) begin
        if (samp_ph == phase_q) begin
          if (dwell_inc > t_cur) viol = FC_TIM;
        end else if (samp_ph == succ_ph) begin
          // An exit from a partially observed phase cannot be judged as early.
          if (!partial_q && ({1'b0, dwell_q} != t_cur)) viol = FC_TIM;
        end else begin
          viol = FC_SEQ;
        end
      end else if (samp_ph != PH_YY) begin
        viol = FC_SEQ;
      end
    end else if (phase_q == PH_YY || phase_q == PH_BB) begin
      if (!modo_q) begin
        if (samp_ph != PH_GR) viol = FC_SEQ;
      end else if (samp_ph == phase_q) begin
        if (dwell_inc > TW_FL) viol = FC_TIM;
      end else if (samp_ph != (phase_q == PH_YY ? PH_BB : PH_YY)) begin
        viol = FC_SEQ;
      end
    end
  end

  // Next-state: phase/dwell tracking, FSM, fault latch and cycle counter.
  always_comb begin
    phase_chg     = !phase_valid_q || (samp_ph != phase_q);
    phase_d       = samp_ph;
    phase_valid_d = 1'b1;
    modo_d        = modo;
    dwell_d       = phase_chg ? DW'(1) : ((dwell_q == {DW{1'b1}}) ? dwell_q : dwell_q + 1'b1);
    state_d       = state_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    cycles_d      = cycles_q;
    partial_d     = phase_chg ? 1'b0 : partial_q;
    if (fault_clr) begin
      // The clearing sample is itself the resynchronisation sample.
      fault_d      = 1'b0;
      fault_code_d = FC_NONE;
      state_d      = TRACK;
      partial_d    = 1'b1;
    end else begin
      case (state_q)
        SYNC: begin
          state_d   = TRACK;
          partial_d = 1'b1;
        end
        TRACK: begin
          if (viol != FC_NONE) begin
            fault_d      = 1'b1;
            fault_code_d = viol;
            state_d      = FAULT;
          end else if (phase_q == PH_RY && samp_ph == PH_GR) begin
            cycles_d = cycles_q + 16'd1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      phase_q       <= PH_GR;
      phase_valid_q <= 1'b0;
      dwell_q       <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      cycles_q      <= '0;
      modo_q        <= 1'b0;
      partial_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      dwell_q       <= dwell_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      cycles_q      <= cycles_d;
      modo_q        <= modo_d;
      partial_q     <= partial_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign dwell       = dwell_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign cycles      = cycles_q;

endmodule
